// File: rtl/idct_block_scheduler_pkg.sv
// Shared types and block-count constants for the milestone 2 IDCT path.
// Also used by the address generator for its U/V plane switch.
package idct_pkg;

    localparam int NUM_BLOCKS_DEF = 2400;
    localparam int Y_BLOCKS_DEF   = 1200;
    localparam int U_BLOCKS_DEF   = 600;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LEAD_FETCH,
        S_LEAD_CT,
        S_CS_FETCH,
        S_CT_WRITE,
        S_LEAD_OUT_WRITE,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_t;

    function automatic plane_t plane_of(
        input logic [11:0] idx,
        input logic [11:0] y_limit,
        input logic [11:0] yu_limit
    );
        if (idx < y_limit) begin
            return PLANE_Y;
        end
        if (idx < yu_limit) begin
            return PLANE_U;
        end
        return PLANE_V;
    endfunction

endpackage

// File: rtl/idct_block_scheduler_if.sv
// Handshake bundle between the block scheduler and the milestone FSM,
// address generator and T/S compute engines.
interface idct_block_scheduler_if;
    import idct_pkg::*;

    logic        start;
    logic        agen_done;
    logic        ct_done;
    logic        cs_done;
    logic        first_cycle;
    logic        fetch_address_enable;
    logic        write_address_enable;
    logic        ct_start;
    logic        cs_start;
    logic [11:0] block_index;
    plane_t      plane;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  agen_done,
        input  ct_done,
        input  cs_done,
        output first_cycle,
        output fetch_address_enable,
        output write_address_enable,
        output ct_start,
        output cs_start,
        output block_index,
        output plane,
        output busy,
        output done
    );

    modport slave (
        output start,
        output agen_done,
        output ct_done,
        output cs_done,
        input  first_cycle,
        input  fetch_address_enable,
        input  write_address_enable,
        input  ct_start,
        input  cs_start,
        input  block_index,
        input  plane,
        input  busy,
        input  done
    );

endinterface

// File: rtl/idct_block_scheduler_done_join.sv
// Sticky two-input rendezvous: bit 0 = address generator, bit 1 = compute.
// A pulse counts in the cycle it arrives, so ready needs no extra cycle.
module done_join (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] arm,
    input  logic [1:0] pulse,
    output logic       ready
);

    logic [1:0] flag_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag_q <= 2'b00;
        end else if (clear) begin
            flag_q <= 2'b00;
        end else begin
            flag_q <= flag_q | (pulse & arm);
        end
    end

    assign ready = &(~arm | flag_q | pulse);

endmodule

// File: rtl/idct_block_scheduler.sv
// Steps through every 8x8 block (Y, U, V), overlapping fetch with S
// compute and write-back with T compute of the following block.
module idct_block_scheduler
    import idct_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int Y_BLOCKS   = Y_BLOCKS_DEF,
    parameter int U_BLOCKS   = U_BLOCKS_DEF
) (
    input logic                    clock,
    input logic                    reset,
    idct_block_scheduler_if.master bus
);

    localparam logic [12:0] BLOCK_LIMIT = 13'(NUM_BLOCKS);
    localparam logic [11:0] Y_LIMIT     = 12'(Y_BLOCKS);
    localparam logic [11:0] YU_LIMIT    = 12'(Y_BLOCKS + U_BLOCKS);

    sched_state_t state_q;
    sched_state_t state_d;
    logic [11:0]  block_index_q;
    logic [11:0]  block_index_d;
    logic         first_cycle_q;
    logic         first_cycle_d;
    logic         fetch_q;
    logic         fetch_d;
    logic         write_q;
    logic         write_d;
    logic         ct_start_q;
    logic         ct_start_d;
    logic         cs_start_q;
    logic         cs_start_d;
    logic         busy_q;
    logic         busy_d;
    logic         done_q;
    logic         done_d;
    logic         enter;
    logic         more_blocks;
    logic         join_ready;
    logic [1:0]   join_arm;
    logic [1:0]   join_pulse;

    assign more_blocks = ({1'b0, block_index_q} + 13'd1) < BLOCK_LIMIT;

    always_comb begin
        join_arm = 2'b00;
        unique case (state_q)
            S_LEAD_FETCH:     join_arm = 2'b01;
            S_LEAD_OUT_WRITE: join_arm = 2'b01;
            S_LEAD_CT:        join_arm = 2'b10;
            S_CS_FETCH:       join_arm = {1'b1, more_blocks};
            S_CT_WRITE:       join_arm = 2'b11;
            default:          join_arm = 2'b00;
        endcase
    end

    // Only CS_FETCH waits on cs_done; every other compute wait is on ct_done.
    assign join_pulse = {
        (state_q == S_CS_FETCH) ? bus.cs_done : bus.ct_done,
        bus.agen_done
    };

    done_join u_join (
        .clock (clock),
        .reset (reset),
        .clear (enter),
        .arm   (join_arm),
        .pulse (join_pulse),
        .ready (join_ready)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            block_index_q <= 12'd0;
            first_cycle_q <= 1'b0;
            fetch_q       <= 1'b0;
            write_q       <= 1'b0;
            ct_start_q    <= 1'b0;
            cs_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_index_q <= block_index_d;
            first_cycle_q <= first_cycle_d;
            fetch_q       <= fetch_d;
            write_q       <= write_d;
            ct_start_q    <= ct_start_d;
            cs_start_q    <= cs_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:           if (bus.start) state_d = S_INIT;
            S_INIT:           state_d = S_LEAD_FETCH;
            S_LEAD_FETCH:     if (join_ready) state_d = S_LEAD_CT;
            S_LEAD_CT:        if (join_ready) state_d = S_CS_FETCH;
            S_CS_FETCH: begin
                if (join_ready) begin
                    state_d = more_blocks ? S_CT_WRITE : S_LEAD_OUT_WRITE;
                end
            end
            S_CT_WRITE:       if (join_ready) state_d = S_CS_FETCH;
            S_LEAD_OUT_WRITE: if (join_ready) state_d = S_DONE;
            S_DONE:           state_d = S_IDLE;
            default:          state_d = S_IDLE;
        endcase

        // Outputs are registered off the state being entered.
        enter         = state_d != state_q;
        first_cycle_d = enter && state_d == S_INIT;
        fetch_d       = enter && (state_d == S_LEAD_FETCH ||
                        (state_d == S_CS_FETCH && more_blocks));
        write_d       = enter && (state_d == S_CT_WRITE ||
                        state_d == S_LEAD_OUT_WRITE);
        ct_start_d    = enter && (state_d == S_LEAD_CT ||
                        state_d == S_CT_WRITE);
        cs_start_d    = enter && state_d == S_CS_FETCH;
        done_d        = enter && state_d == S_DONE;
        busy_d        = state_d != S_IDLE;

        block_index_d = block_index_q;
        if (state_d == S_INIT) begin
            block_index_d = 12'd0;
        end else if (enter && state_d == S_CT_WRITE) begin
            block_index_d = block_index_q + 12'd1;
        end
    end

    assign bus.first_cycle          = first_cycle_q;
    assign bus.fetch_address_enable = fetch_q;
    assign bus.write_address_enable = write_q;
    assign bus.ct_start             = ct_start_q;
    assign bus.cs_start             = cs_start_q;
    assign bus.block_index          = block_index_q;
    assign bus.plane   = plane_of(block_index_q, Y_LIMIT, YU_LIMIT);
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Bench for idct_block_scheduler: three sizes (1, 3, default blocks)
// driven by responders with chosen latencies against a step-list model.
module tb_idct_block_scheduler;
    import idct_pkg::*;

    localparam logic [5:0] V_FC = 6'b100000;
    localparam logic [5:0] V_FE = 6'b010000;
    localparam logic [5:0] V_WE = 6'b001000;
    localparam logic [5:0] V_CT = 6'b000100;
    localparam logic [5:0] V_CS = 6'b000010;
    localparam logic [5:0] V_DN = 6'b000001;
    localparam int A_AG = 1;
    localparam int A_CT = 2;
    localparam int A_CS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       agen_done = 1'b0;
    logic       ct_done = 1'b0;
    logic       cs_done = 1'b0;
    logic [1:0] sel = 2'd0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    logic [5:0]  o_vec;
    logic [11:0] o_bi;
    logic [1:0]  o_plane;
    logic        o_busy;

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    idct_block_scheduler_if b0 ();
    idct_block_scheduler_if b1 ();
    idct_block_scheduler_if b2 ();

    assign b0.start     = start && sel == 2'd0;
    assign b0.agen_done = agen_done && sel == 2'd0;
    assign b0.ct_done   = ct_done && sel == 2'd0;
    assign b0.cs_done   = cs_done && sel == 2'd0;
    assign b1.start     = start && sel == 2'd1;
    assign b1.agen_done = agen_done && sel == 2'd1;
    assign b1.ct_done   = ct_done && sel == 2'd1;
    assign b1.cs_done   = cs_done && sel == 2'd1;
    assign b2.start     = start && sel == 2'd2;
    assign b2.agen_done = agen_done && sel == 2'd2;
    assign b2.ct_done   = ct_done && sel == 2'd2;
    assign b2.cs_done   = cs_done && sel == 2'd2;

    idct_block_scheduler #(
        .NUM_BLOCKS(1), .Y_BLOCKS(1), .U_BLOCKS(0)
    ) dut0 (.clock(clock), .reset(reset), .bus(b0));

    idct_block_scheduler #(
        .NUM_BLOCKS(3), .Y_BLOCKS(1), .U_BLOCKS(1)
    ) dut1 (.clock(clock), .reset(reset), .bus(b1));

    idct_block_scheduler dut2 (.clock(clock), .reset(reset), .bus(b2));

    always_comb begin
        o_vec = 6'd0;
        o_bi = 12'd0;
        o_plane = 2'd0;
        o_busy = 1'b0;
        case (sel)
            2'd0: begin
                o_vec = {b0.first_cycle, b0.fetch_address_enable,
                         b0.write_address_enable, b0.ct_start,
                         b0.cs_start, b0.done};
                o_bi = b0.block_index;
                o_plane = b0.plane;
                o_busy = b0.busy;
            end
            2'd1: begin
                o_vec = {b1.first_cycle, b1.fetch_address_enable,
                         b1.write_address_enable, b1.ct_start,
                         b1.cs_start, b1.done};
                o_bi = b1.block_index;
                o_plane = b1.plane;
                o_busy = b1.busy;
            end
            2'd2: begin
                o_vec = {b2.first_cycle, b2.fetch_address_enable,
                         b2.write_address_enable, b2.ct_start,
                         b2.cs_start, b2.done};
                o_bi = b2.block_index;
                o_plane = b2.plane;
                o_busy = b2.busy;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_plane(int bi, int y, int u);
        if (bi < y) return 0;
        if (bi < y + u) return 1;
        return 2;
    endfunction

    // mode 0 random, 1 agen 10 early, 2 compute 10 early,
    // 3 equal, 4 zero latency, 5 fixed 5 cycles
    function automatic int dly(int mode, bit is_agen);
        case (mode)
            0: return int'($urandom_range(0, 6));
            1: return is_agen ? 1 : 11;
            2: return is_agen ? 11 : 1;
            3: return 3;
            4: return 0;
            default: return 5;
        endcase
    endfunction

    task automatic run_pass(input logic [1:0] s_sel, input int n,
                            input int y, input int u, input int mode,
                            input bit spur, input int abort);
        logic [5:0] ev[$];
        int eb[$];
        int ea[$];
        int ns, s, t0, exp_at, ag_t, ct_t, cs_t, aw, cur, budget;
        int n_fe, n_we, n_ct, n_cs;
        ev.push_back(V_FC); eb.push_back(0); ea.push_back(0);
        ev.push_back(V_FE); eb.push_back(0); ea.push_back(A_AG);
        ev.push_back(V_CT); eb.push_back(0); ea.push_back(A_CT);
        for (int k = 0; k < n; k++) begin
            if (k + 1 < n) begin
                ev.push_back(V_CS | V_FE); eb.push_back(k);
                ea.push_back(A_CS | A_AG);
                ev.push_back(V_CT | V_WE); eb.push_back(k + 1);
                ea.push_back(A_CT | A_AG);
            end else begin
                ev.push_back(V_CS); eb.push_back(k); ea.push_back(A_CS);
            end
        end
        ev.push_back(V_WE); eb.push_back(n - 1); ea.push_back(A_AG);
        ev.push_back(V_DN); eb.push_back(n - 1); ea.push_back(0);
        ns = ev.size();
        s = 0;
        ag_t = -1; ct_t = -1; cs_t = -1;
        n_fe = 0; n_we = 0; n_ct = 0; n_cs = 0;
        budget = 100 + n * 40;
        @(negedge clock);
        sel = s_sel;
        start = 1'b1;
        t0 = cyc;
        exp_at = t0 + 1;
        while (1) begin
            @(negedge clock);
            start = 1'b0;
            agen_done = 1'b0;
            ct_done = 1'b0;
            cs_done = 1'b0;
            if (abort > 0 && cyc - t0 >= abort) break;
            if (cyc - t0 > budget) begin
                chk("timeout_step", s, ns);
                break;
            end
            n_fe += int'(o_vec[4]);
            n_we += int'(o_vec[3]);
            n_ct += int'(o_vec[2]);
            n_cs += int'(o_vec[1]);
            if (s == ns) begin
                chk("busy_fall", o_busy, 0);
                chk("idle_quiet", o_vec, 0);
                break;
            end
            if (cyc == exp_at) begin
                chk("step_vec", o_vec, ev[s]);
                chk("step_busy", o_busy, 1);
                if (s > 0) begin
                    chk("step_index", o_bi, eb[s]);
                    chk("step_plane", o_plane, exp_plane(eb[s], y, u));
                end
                aw = ea[s];
                exp_at = cyc + 1;
                if ((aw & A_AG) != 0) begin
                    ag_t = cyc + dly(mode, 1'b1);
                    if (ag_t + 1 > exp_at) exp_at = ag_t + 1;
                end
                if ((aw & A_CT) != 0) begin
                    ct_t = cyc + dly(mode, 1'b0);
                    if (ct_t + 1 > exp_at) exp_at = ct_t + 1;
                end
                if ((aw & A_CS) != 0) begin
                    cs_t = cyc + dly(mode, 1'b0);
                    if (cs_t + 1 > exp_at) exp_at = cs_t + 1;
                end
                s++;
            end else begin
                chk("quiet_vec", o_vec, 0);
                chk("mid_busy", o_busy, s > 0);
            end
            agen_done = cyc == ag_t;
            ct_done = cyc == ct_t;
            cs_done = cyc == cs_t;
            if (spur && s > 0) begin
                cur = ea[s - 1];
                if ((cur & A_AG) == 0 && $urandom_range(0, 7) == 0)
                    agen_done = 1'b1;
                if ((cur & A_CT) == 0 && $urandom_range(0, 7) == 0)
                    ct_done = 1'b1;
                if ((cur & A_CS) == 0 && $urandom_range(0, 3) == 0)
                    cs_done = 1'b1;
                if (s == ns || $urandom_range(0, 5) == 0)
                    start = 1'b1;
            end
        end
        start = 1'b0;
        agen_done = 1'b0;
        ct_done = 1'b0;
        cs_done = 1'b0;
        if (abort == 0) begin
            chk("total_fetch", n_fe, n);
            chk("total_write", n_we, n);
            chk("total_ct", n_ct, n);
            chk("total_cs", n_cs, n);
        end
    endtask

    initial begin
        #5;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            chk("rst_vec", o_vec, 0);
            chk("rst_index", o_bi, 0);
            chk("rst_plane", o_plane, 0);
            chk("rst_busy", o_busy, 0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_pass(2'd0, 1, 1, 0, 5, 1'b0, 0);
        run_pass(2'd1, 3, 1, 1, 1, 1'b0, 0);
        run_pass(2'd1, 3, 1, 1, 2, 1'b0, 0);
        run_pass(2'd1, 3, 1, 1, 3, 1'b0, 0);
        run_pass(2'd1, 3, 1, 1, 0, 1'b1, 0);
        run_pass(2'd0, 1, 1, 0, 0, 1'b1, 0);

        run_pass(2'd1, 3, 1, 1, 3, 1'b0, 15);
        chk("pre_rst_busy", o_busy, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_vec", o_vec, 0);
        chk("mid_rst_index", o_bi, 0);
        chk("mid_rst_plane", o_plane, 0);
        chk("mid_rst_busy", o_busy, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("post_rst_busy", o_busy, 0);
            chk("post_rst_vec", o_vec, 0);
        end
        run_pass(2'd1, 3, 1, 1, 0, 1'b0, 0);

        run_pass(2'd2, NUM_BLOCKS_DEF, Y_BLOCKS_DEF, U_BLOCKS_DEF,
                 4, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idct_block_scheduler.md
# idct_block_scheduler

Sequencing controller for the milestone 2 IDCT datapath. It steps through all 8x8 blocks of the S' image: Y first, then U, then V. For each block it drives the address generator's fetch and write enables and the T/S compute engines. The fetch of block k+1 overlaps the S computation of block k, and the write of block k overlaps the T computation of block k+1. It sits between the top-level milestone FSM and the address generator / multiplier datapath.

## Interface
Parameters:
- NUM_BLOCKS, 2400: total blocks (Y 1200 + U 600 + V 600).
- Y_BLOCKS, 1200: blocks in the Y plane.
- U_BLOCKS, 600: blocks in the U plane.

Ports:
- clock  in  1  50 MHz clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a full pass; ignored unless idle.
- agen_done  in  1  one-cycle pulse from the address generator when a fetch or write of 64 values completes.
- ct_done  in  1  one-cycle pulse when T = S'C for a block is finished.
- cs_done  in  1  one-cycle pulse when S = CᵀT for a block is finished.
- first_cycle  out  1  one-cycle pulse that clears the address generator counters.
- fetch_address_enable  out  1  one-cycle pulse that starts a 64-value fetch.
- write_address_enable  out  1  one-cycle pulse that starts a 64-value (32-pair) write.
- ct_start  out  1  one-cycle pulse that starts the T computation.
- cs_start  out  1  one-cycle pulse that starts the S computation.
- block_index  out  12  index of the block currently in CT or CS.
- plane  out  2  plane of block_index: 0 = Y, 1 = U, 2 = V.
- busy  out  1  high from the INIT state through the DONE state.
- done  out  1  one-cycle pulse when the pass completes.

## Operation
- States: IDLE, INIT, LEAD_FETCH, LEAD_CT, CS_FETCH, CT_WRITE, LEAD_OUT_WRITE, DONE.
- IDLE --start--> INIT. INIT asserts first_cycle and moves unconditionally to LEAD_FETCH.
- LEAD_FETCH: pulse fetch_address_enable, wait for agen_done, then go to LEAD_CT.
- LEAD_CT: pulse ct_start, wait for ct_done, then go to CS_FETCH.
- CS_FETCH: pulse cs_start.
  - If block_index+1 < NUM_BLOCKS, also pulse fetch_address_enable and join on cs_done and agen_done.
  - Otherwise join on cs_done only and exit to LEAD_OUT_WRITE.
  - A normal exit goes to CT_WRITE.
- CT_WRITE: increment block_index on entry, pulse ct_start and write_address_enable, join on ct_done and agen_done, then go to CS_FETCH.
- LEAD_OUT_WRITE: pulse write_address_enable, wait for agen_done, then go to DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- Join logic:
  - A sticky flag per awaited pulse, cleared on state entry.
  - The join is satisfied by flag OR the same-cycle pulse.
  - Pulses arriving for an event the current state does not await are ignored.
- fetch_address_enable and write_address_enable are never high in the same cycle; the address generator serves one direction at a time.
- plane is decoded combinationally from block_index:
  - Y when block_index < Y_BLOCKS.
  - U when block_index < Y_BLOCKS+U_BLOCKS.
  - V otherwise.
- block_index is 12-bit unsigned, reset to 0 in INIT, and never exceeds NUM_BLOCKS-1.
- Edge case NUM_BLOCKS = 1: the path is LEAD_FETCH, LEAD_CT, CS_FETCH (no fetch), LEAD_OUT_WRITE, DONE.
- Per pass there are exactly NUM_BLOCKS fetch, write, ct_start and cs_start pulses each.

## Timing
- All outputs are registered except plane.
- Reset values: state IDLE and every output 0, including block_index.
- start high at edge n: INIT (first_cycle=1, busy=1) during cycle n+1, LEAD_FETCH with fetch_address_enable=1 during cycle n+2.
- Start pulses are high only in the first cycle of a state.
- Advance latency: the final awaited pulse high in cycle c gives the next state, with its start pulses, in cycle c+1.
- Simultaneous done pulses in the same cycle satisfy the join, so the state advances the next cycle.
- start is ignored while busy, including in the cycle DONE is asserted.
- Reset mid-operation clears state, flags and outputs immediately. A later start begins a fresh pass with a first_cycle pulse.

## Structure
- Shared package idct_pkg holds:
  - the state enum type;
  - the plane enum (PLANE_Y / PLANE_U / PLANE_V);
  - block count constants.
- The address generator uses the same package constants for its U/V switch.
- One sub-module, done_join: the sticky two-input rendezvous (clear, arm mask, pulse inputs, ready output), instantiated once.

## Test plan
- Reset asserted mid-stream: all outputs 0 in the same cycle, and IDLE after release; next start yields first_cycle exactly one cycle later.
- NUM_BLOCKS=1, responders delay 5 cycles each: pulse order is first_cycle, fetch, ct, cs, write, done; one of each; fetch never during CS.
- NUM_BLOCKS=3, agen_done 10 cycles before compute done, then the reverse: advance occurs 1 cycle after the later pulse; totals are 3 fetch / 3 write / 3 ct / 3 cs.
- ct_done and agen_done in the same cycle in CT_WRITE: CS_FETCH entered next cycle with cs_start=1 and block_index incremented.
- start pulsed while busy, plus a spurious cs_done during CT_WRITE: both ignored and the sequence is unchanged.
- Default parameters, zero-latency responders: plane changes 0→1 at block_index 1200 and 1→2 at 1800; done after the 2400th write pulse, and busy falls the following cycle.
